// File: rtl/ama_riscv_perf_pkg.sv
// Shared definitions for the performance counter block: MMIO word map, counter ids
// and the counter width.
package ama_riscv_perf_pkg;

  localparam int unsigned PERF_CNT_W   = 64;
  localparam int unsigned PERF_WORD_W  = 32;
  localparam int unsigned PERF_NUM_CNT = 3;

  // MMIO word indices; each counter occupies a lo/hi pair
  localparam logic [2:0] PERF_CYCLE_LO   = 3'd0;
  localparam logic [2:0] PERF_CYCLE_HI   = 3'd1;
  localparam logic [2:0] PERF_INSTRET_LO = 3'd2;
  localparam logic [2:0] PERF_INSTRET_HI = 3'd3;
  localparam logic [2:0] PERF_STALL_LO   = 3'd4;
  localparam logic [2:0] PERF_STALL_HI   = 3'd5;
  localparam logic [2:0] PERF_STATUS     = 3'd6;
  localparam logic [2:0] PERF_RSVD       = 3'd7;

  typedef enum logic [1:0] {
    CYC     = 2'd0,
    INSTRET = 2'd1,
    STALL   = 2'd2
  } perf_cnt_id_e;

endpackage

// File: rtl/ama_riscv_perf_cnt_unit.sv
// One wrapping counter with a sticky overflow flag and a hi-word shadow that is
// captured whenever software reads the matching lo word.
module ama_riscv_perf_cnt_unit
  import ama_riscv_perf_pkg::*;
#(
  parameter int unsigned CNT_W = PERF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  input  logic               snap,
  output logic [CNT_W-1:0]   cnt,
  output logic [CNT_W/2-1:0] hi_shadow,
  output logic               ovf
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W/2-1:0] hi_shadow_q, hi_shadow_d;
  logic               ovf_q, ovf_d;

  // clr is applied last so it beats both an increment and a snapshot in the same cycle
  always_comb begin
    cnt_d       = cnt_q;
    hi_shadow_d = hi_shadow_q;
    ovf_d       = ovf_q;
    if (snap) begin
      hi_shadow_d = cnt_q[CNT_W-1:CNT_W/2];
    end
    if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end
    end
    if (clr) begin
      cnt_d       = '0;
      hi_shadow_d = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      hi_shadow_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hi_shadow_q <= hi_shadow_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cnt       = cnt_q;
  assign hi_shadow = hi_shadow_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/ama_riscv_perf_cnt.sv
// Cycle / retired-instruction / stall counters behind a one-cycle-latency MMIO read
// port with lo-then-hi snapshot semantics.
module ama_riscv_perf_cnt
  import ama_riscv_perf_pkg::*;
#(
  parameter int unsigned CNT_W  = PERF_CNT_W,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic              inst_wb_nop_or_clear,
  input  logic              stall_id,
  input  logic              mmio_reset_cnt,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid
);

  logic [PERF_NUM_CNT-1:0] inc;
  logic [PERF_NUM_CNT-1:0] snap;
  logic [PERF_NUM_CNT-1:0] ovf;

  logic [CNT_W-1:0]   cnt_cyc, cnt_instret, cnt_stall;
  logic [CNT_W/2-1:0] hi_cyc, hi_instret, hi_stall;

  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  // A lo read snapshots its counter's upper half so the following hi read is coherent
  always_comb begin
    inc           = '0;
    snap          = '0;
    inc[CYC]      = cnt_en;
    inc[INSTRET]  = cnt_en & ~inst_wb_nop_or_clear;
    inc[STALL]    = cnt_en & stall_id;
    snap[CYC]     = rd_en & (rd_addr == ADDR_W'(PERF_CYCLE_LO));
    snap[INSTRET] = rd_en & (rd_addr == ADDR_W'(PERF_INSTRET_LO));
    snap[STALL]   = rd_en & (rd_addr == ADDR_W'(PERF_STALL_LO));
  end

  ama_riscv_perf_cnt_unit #(.CNT_W(CNT_W)) u_cyc (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc[CYC]),
    .clr       (mmio_reset_cnt),
    .snap      (snap[CYC]),
    .cnt       (cnt_cyc),
    .hi_shadow (hi_cyc),
    .ovf       (ovf[CYC])
  );

  ama_riscv_perf_cnt_unit #(.CNT_W(CNT_W)) u_instret (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc[INSTRET]),
    .clr       (mmio_reset_cnt),
    .snap      (snap[INSTRET]),
    .cnt       (cnt_instret),
    .hi_shadow (hi_instret),
    .ovf       (ovf[INSTRET])
  );

  ama_riscv_perf_cnt_unit #(.CNT_W(CNT_W)) u_stall (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc[STALL]),
    .clr       (mmio_reset_cnt),
    .snap      (snap[STALL]),
    .cnt       (cnt_stall),
    .hi_shadow (hi_stall),
    .ovf       (ovf[STALL])
  );

  // Hi words are served from the shadows, so the live upper halves are never read here
  logic unused_cnt_hi;
  assign unused_cnt_hi = ^{cnt_cyc[CNT_W-1:32], cnt_instret[CNT_W-1:32],
                           cnt_stall[CNT_W-1:32]};

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      case (rd_addr)
        ADDR_W'(PERF_CYCLE_LO):   rd_data_d = cnt_cyc[31:0];
        ADDR_W'(PERF_CYCLE_HI):   rd_data_d = hi_cyc;
        ADDR_W'(PERF_INSTRET_LO): rd_data_d = cnt_instret[31:0];
        ADDR_W'(PERF_INSTRET_HI): rd_data_d = hi_instret;
        ADDR_W'(PERF_STALL_LO):   rd_data_d = cnt_stall[31:0];
        ADDR_W'(PERF_STALL_HI):   rd_data_d = hi_stall;
        ADDR_W'(PERF_STATUS):     rd_data_d = {28'b0, ovf[STALL], ovf[INSTRET], ovf[CYC], cnt_en};
        ADDR_W'(PERF_RSVD):       rd_data_d = '0;
        default:                  rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ama_riscv_perf_cnt.sv
// Directed plus randomized bench for ama_riscv_perf_cnt, checked against a
// cycle-level reference model of the three counters and the read port.
module tb_ama_riscv_perf_cnt;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_en;
  logic        inst_wb_nop_or_clear;
  logic        stall_id;
  logic        mmio_reset_cnt;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: plain 64-bit integers, sticky flags and captured hi halves
  logic [63:0] m_cnt    [3];
  logic        m_ovf    [3];
  logic [31:0] m_shadow [3];
  logic [31:0] exp_data;
  logic        exp_valid;
  logic [31:0] saved;

  always #5 clk = ~clk;

  ama_riscv_perf_cnt #(.CNT_W(64), .ADDR_W(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cnt_en               (cnt_en),
    .inst_wb_nop_or_clear (inst_wb_nop_or_clear),
    .stall_id             (stall_id),
    .mmio_reset_cnt       (mmio_reset_cnt),
    .rd_en                (rd_en),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data),
    .rd_valid             (rd_valid)
  );

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic en);
    logic [31:0] v;
    case (a)
      3'd0:    v = m_cnt[0][31:0];
      3'd1:    v = m_shadow[0];
      3'd2:    v = m_cnt[1][31:0];
      3'd3:    v = m_shadow[1];
      3'd4:    v = m_cnt[2][31:0];
      3'd5:    v = m_shadow[2];
      3'd6:    v = {28'b0, m_ovf[2], m_ovf[1], m_ovf[0], en};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]    = 64'h0;
      m_ovf[i]    = 1'b0;
      m_shadow[i] = 32'h0;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic nop, input logic stl,
                               input logic clr, input logic rd, input logic [2:0] addr);
    logic [2:0] hit;
    @(negedge clk);
    cnt_en               = en;
    inst_wb_nop_or_clear = nop;
    stall_id             = stl;
    mmio_reset_cnt       = clr;
    rd_en                = rd;
    rd_addr              = addr;
    @(posedge clk);
    if (rd) exp_data = model_read(addr, en);
    exp_valid = rd;
    hit = {en && stl, en && !nop, en};
    for (int i = 0; i < 3; i++) begin
      if (rd && addr == 3'(2 * i)) m_shadow[i] = m_cnt[i][63:32];
      if (hit[i]) begin
        m_cnt[i] = m_cnt[i] + 64'd1;
        if (m_cnt[i] == 64'd0) m_ovf[i] = 1'b1;
      end
    end
    if (clr) model_clear();
    #1;
    checkOutput($sformatf("rd_valid(addr%0d)", addr), {31'b0, rd_valid}, {31'b0, exp_valid});
    checkOutput($sformatf("rd_data(addr%0d)", addr), rd_data, exp_data);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst                  = 1'b1;
    cnt_en               = 1'b0;
    inst_wb_nop_or_clear = 1'b0;
    stall_id             = 1'b0;
    mmio_reset_cnt       = 1'b0;
    rd_en                = 1'b0;
    rd_addr              = 3'd0;
    @(posedge clk);
    model_clear();
    exp_valid = 1'b0;
    exp_data  = 32'h0;
    #1;
    checkOutput("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    checkOutput("rst_rd_data", rd_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cnt_en = 1'b0; inst_wb_nop_or_clear = 1'b0; stall_id = 1'b0;
    mmio_reset_cnt = 1'b0; rd_en = 1'b0; rd_addr = 3'd0;
    exp_data = 32'h0; exp_valid = 1'b0;
    model_clear();
    doReset();

    // Plain counting: every cycle is a retire, no stalls
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 3'd0); checkOutput("cycle_lo_10", rd_data, 32'd10);
    applyStimulus(0, 0, 0, 0, 1, 3'd1); checkOutput("cycle_hi_0", rd_data, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 3'd2); checkOutput("instret_lo_10", rd_data, 32'd10);
    applyStimulus(0, 0, 0, 0, 1, 3'd3); checkOutput("instret_hi_0", rd_data, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 3'd4); checkOutput("stall_lo_0", rd_data, 32'd0);

    // Mixed bubbles and stalls over 8 cycles
    applyStimulus(0, 0, 0, 1, 0, 3'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1'(i % 2), 1'(i < 3), 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 3'd2); checkOutput("instret_lo_4", rd_data, 32'd4);
    applyStimulus(0, 0, 0, 0, 1, 3'd4); checkOutput("stall_lo_3", rd_data, 32'd3);
    applyStimulus(0, 0, 0, 0, 1, 3'd0); checkOutput("cycle_lo_8", rd_data, 32'd8);

    // Carry into the upper word and hi-shadow coherence
    force dut.u_cyc.cnt_q = 64'h0000_0000_FFFF_FFFF;
    applyStimulus(0, 0, 0, 0, 0, 3'd0);
    release dut.u_cyc.cnt_q;
    m_cnt[0] = 64'h0000_0000_FFFF_FFFF;
    applyStimulus(1, 1, 0, 0, 0, 3'd0);
    applyStimulus(1, 1, 0, 0, 1, 3'd0); checkOutput("cycle_lo_carry", rd_data, 32'h0);
    applyStimulus(1, 1, 0, 0, 1, 3'd1); checkOutput("cycle_hi_carry", rd_data, 32'h1);

    // Instret wrap sets its sticky flag; mmio reset clears it
    force dut.u_instret.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(0, 0, 0, 0, 0, 3'd0);
    release dut.u_instret.cnt_q;
    m_cnt[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(1, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 3'd2); checkOutput("instret_wrap_lo", rd_data, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 3'd6); checkOutput("status_ovf_instret", rd_data, 32'h4);
    applyStimulus(1, 0, 0, 1, 0, 3'd0);
    applyStimulus(1, 0, 0, 0, 1, 3'd6); checkOutput("status_after_clr", rd_data, 32'h1);

    // Read coincident with mmio reset returns the pre-reset value
    applyStimulus(0, 0, 0, 1, 0, 3'd0);
    for (int i = 0; i < 50; i++) applyStimulus(1, 0, 0, 0, 0, 3'd0);
    applyStimulus(1, 0, 0, 1, 1, 3'd0); checkOutput("read_with_clr", rd_data, 32'd50);
    applyStimulus(1, 0, 0, 0, 1, 3'd0); checkOutput("read_after_clr", rd_data, 32'd0);
    applyStimulus(1, 0, 0, 0, 1, 3'd0); checkOutput("read_resume", rd_data, 32'd1);

    // Disabled counting ignores retires and stalls
    saved = m_cnt[2][31:0];
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 3'd4); checkOutput("stall_frozen", rd_data, saved);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    // rst with a read in flight drops it and zeroes everything
    applyStimulus(1, 0, 1, 0, 1, 3'd0);
    doReset();
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 0, 0, 1, 3'(a));
      checkOutput($sformatf("post_rst_zero(addr%0d)", a), rd_data, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ama_riscv_perf_cnt.md
# ama_riscv_perf_cnt

Performance counter block that sits directly downstream of `ama_riscv_core` in `ama_riscv_core_top`. It consumes the core's writeback retire indication, front-end stall and counter-reset request, and maintains 64-bit cycle, retired-instruction and stall-cycle counters. The counters are exposed through a small MMIO read port with low/high snapshot semantics. The bench checks these counters against its own retire statistics at end of test.

## Interface
Parameters:
- `CNT_W`, 64: counter width; must be 64, because the read map splits each counter into two 32-bit words.
- `ADDR_W`, 3: MMIO word-index width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `cnt_en`  in  1  global count enable (1 = counting).
- `inst_wb_nop_or_clear`  in  1  1 = writeback slot holds a bubble or flushed instruction; 0 = real retire.
- `stall_id`  in  1  decode-stage stall this cycle.
- `mmio_reset_cnt`  in  1  single-cycle pulse that clears all counters and the overflow flags.
- `rd_en`  in  1  MMIO read request.
- `rd_addr`  in  `ADDR_W`  word index.
- `rd_data`  out  32  read data.
- `rd_valid`  out  1  read data valid.

## Operation
- Counter increment conditions, evaluated each clock:
  - `cycle_cnt` increments when `cnt_en`=1.
  - `instret_cnt` increments when `cnt_en`=1 and `inst_wb_nop_or_clear`=0.
  - `stall_cnt` increments when `cnt_en`=1 and `stall_id`=1.
- All arithmetic is unsigned modulo 2^64.
  - On wrap from 0xFFFF_FFFF_FFFF_FFFF to 0, the per-counter sticky overflow bit `ovf[i]` is set.
- `mmio_reset_cnt`=1: all three counters, all `ovf` bits and all hi shadows are set to 0 on the next edge.
  - Reset has priority over an increment in the same cycle, so the counter value is 0 after that edge, not 1.
- Read map by word index:
  - 0: cycle_lo
  - 1: cycle_hi
  - 2: instret_lo
  - 3: instret_hi
  - 4: stall_lo
  - 5: stall_hi
  - 6: status = {28'b0, ovf[2:0], cnt_en}, with ovf order stall, instret, cycle from bit 3 down to bit 1.
  - 7: reads 0.
- Snapshot rule:
  - Reading a lo word latches the matching counter's upper 32 bits into that counter's hi shadow in the same cycle.
  - Reading a hi word returns the shadow, not the live value. Software reads lo then hi and gets a coherent 64-bit value.
  - Reading a hi word without a prior lo read returns the shadow's last value, which is 0 after reset.
- Read data reflects counter values before the current cycle's update.
- A read issued in the same cycle as `mmio_reset_cnt` returns the pre-reset value.
  - The shadow latched by that read is then cleared by the reset.

## Timing
- Read latency is 1 cycle: `rd_en` at cycle N gives `rd_valid`=1 and `rd_data` at cycle N+1.
- Back-to-back reads are allowed every cycle. There is no backpressure.
- `rd_valid`=0 in any cycle not following a `rd_en`. `rd_data` holds its last value when `rd_valid`=0.
- An increment condition at cycle N is visible in a read issued at cycle N+1.
- `rst`, checked at each edge, sets every register to 0:
  - counters, shadows and `ovf`;
  - `rd_valid`=0 and `rd_data`=0.
- A read in flight when `rst` asserts is dropped; `rd_valid`=0 on the cycle after.
- The first increment can occur on the first edge with `rst`=0.

## Structure
- Shared package `ama_riscv_perf_pkg`:
  - `localparam` word indices: `PERF_CYCLE_LO` … `PERF_STATUS`;
  - `typedef enum` for counter id (CYC, INSTRET, STALL);
  - `PERF_CNT_W`=64.
- One sub-module, `ama_riscv_perf_cnt_unit`, instantiated three times:
  - a 64-bit counter with `inc`, `clr`, `snap` inputs;
  - outputs `cnt`, `hi_shadow`, `ovf`.
- The top level holds the read-address decode and the output register.

## Test plan
- Reset, then 10 cycles with `cnt_en`=1, `inst_wb_nop_or_clear`=0, `stall_id`=0, then read idx 0,1,2,3,4 -> cycle_lo=10 (reads at the sampled point), cycle_hi=0, instret_lo=10, instret_hi=0, stall_lo=0.
- Alternate `inst_wb_nop_or_clear` 0/1 and hold `stall_id`=1 for 3 of 8 cycles -> instret_lo=4, stall_lo=3, cycle_lo=8.
- Force `cycle_cnt`=0x0000_0000_FFFF_FFFF, step one cycle, read idx 0 then idx 1 -> 0x0000_0000 then 0x0000_0001. A further increment between the two reads does not change the hi value returned.
- Force `instret_cnt`=all-ones, retire once -> instret reads 0, and status bit 2 = 1. Then pulse `mmio_reset_cnt` -> status = 0x1.
- Assert `mmio_reset_cnt` together with `rd_en` idx 0 while `cycle_cnt`=50 -> `rd_data`=50 next cycle, and a following read of idx 0 returns 0 or 1 consistent with the reset-wins rule (0 at the edge, counting resumes after).
- Set `cnt_en`=0 for 5 cycles with retires and stalls active -> all counters unchanged.
- Assert `rst` with a read pending -> `rd_valid`=0 and all reads after reset return 0.
